// File: rtl/shift_seq_ctrl.sv
// Multi-pass shift sequencer: breaks a 0..15-bit shift into passes of at most
// MAX_STEP bits through a narrow shifter, with a start/busy/done handshake.
module shift_seq_ctrl #(
    parameter int WIDTH    = 8,
    parameter int SHAMT_W  = 4,
    parameter int MAX_STEP = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   d_in,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   d_out
);

    localparam int STEP_W = $clog2(MAX_STEP + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_LSL = 2'b00,
        OP_LSR = 2'b01,
        OP_ASR = 2'b10,
        OP_ROR = 2'b11
    } op_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [SHAMT_W-1:0] rem_q, rem_d;
    op_t                op_q, op_d;
    logic [WIDTH-1:0]   dout_q, dout_d;

    logic [STEP_W-1:0]  step;
    logic [WIDTH-1:0]   shifted;

    // Step derives from the remaining amount so the last pass never overshoots.
    always_comb begin
        if (rem_q > SHAMT_W'(MAX_STEP)) step = STEP_W'(MAX_STEP);
        else                            step = rem_q[STEP_W-1:0];
    end

    always_comb begin
        logic [2*WIDTH-1:0] dbl;
        logic signed [WIDTH-1:0] sacc;
        dbl     = {acc_q, acc_q} >> step;
        sacc    = $signed(acc_q) >>> step;
        shifted = acc_q;
        case (op_q)
            OP_LSL:  shifted = acc_q << step;
            OP_LSR:  shifted = acc_q >> step;
            OP_ASR:  shifted = sacc;
            OP_ROR:  shifted = dbl[WIDTH-1:0];
            default: shifted = acc_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        op_d    = op_q;
        dout_d  = dout_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d = d_in;
                    rem_d = shamt;
                    op_d  = op_t'(op);
                    if (shamt == '0) begin
                        state_d = DONE;
                        dout_d  = d_in;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                acc_d = shifted;
                rem_d = rem_q - SHAMT_W'(step);
                if (rem_d == '0) begin
                    state_d = DONE;
                    dout_d  = shifted;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            rem_q   <= '0;
            op_q    <= OP_LSL;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
            dout_q  <= dout_d;
        end
    end

    assign busy  = (state_q != IDLE);
    assign done  = (state_q == DONE);
    assign d_out = dout_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl: latency, results, start-ignore and reset abort.
module tb_shift_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] op;
    logic [7:0] d_in;
    logic [3:0] shamt;
    logic       busy;
    logic       done;
    logic [7:0] d_out;

    int checks   = 0;
    int failures = 0;

    shift_seq_ctrl #(.WIDTH(8), .SHAMT_W(4), .MAX_STEP(3)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .d_in  (d_in),
        .shamt (shamt),
        .busy  (busy),
        .done  (done),
        .d_out (d_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    // Issue one command and follow it to completion; n = expected pass count.
    task automatic run_cmd(input logic [1:0] o, input logic [7:0] d, input logic [3:0] s,
                           input logic [7:0] exp, input int n, input string tag);
        int lat;
        logic [7:0] prev;
        prev  = d_out;
        op    = o;
        d_in  = d;
        shamt = s;
        start = 1'b1;
        step_clk();
        start = 1'b0;
        d_in  = 8'h00;
        lat   = 1;
        while (!done && lat < 40) begin
            chk({tag, " busy_in_shift"}, busy, 1);
            chk({tag, " dout_hold"}, d_out, prev);
            step_clk();
            lat++;
        end
        chk({tag, " latency"}, lat, n + 1);
        chk({tag, " done"}, done, 1);
        chk({tag, " busy_in_done"}, busy, 1);
        chk({tag, " d_out"}, d_out, exp);
        step_clk();
        chk({tag, " done_one_cycle"}, done, 0);
        chk({tag, " idle_busy"}, busy, 0);
        chk({tag, " d_out_held"}, d_out, exp);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        d_in  = 8'h00;
        shamt = 4'h0;
        step_clk();
        step_clk();
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset d_out", d_out, 8'h00);
        reset = 1'b0;
        step_clk();
        chk("idle no start", busy, 0);

        run_cmd(2'b00, 8'hB5, 4'd2,  8'hD4, 1, "lsl_b5_2");
        run_cmd(2'b00, 8'h01, 4'd7,  8'h80, 3, "lsl_01_7");
        run_cmd(2'b10, 8'h90, 4'd4,  8'hF9, 2, "asr_90_4");
        run_cmd(2'b10, 8'h90, 4'd15, 8'hFF, 5, "asr_90_15");
        run_cmd(2'b11, 8'h81, 4'd9,  8'hC0, 3, "ror_81_9");
        run_cmd(2'b01, 8'hFF, 4'd12, 8'h00, 4, "lsr_ff_12");
        run_cmd(2'b01, 8'h5A, 4'd0,  8'h5A, 0, "lsr_5a_0");
        run_cmd(2'b11, 8'h96, 4'd8,  8'h96, 3, "ror_96_8");

        // start held high with new data through SHIFT and DONE must be ignored
        op = 2'b11; d_in = 8'h0F; shamt = 4'd6; start = 1'b1;
        step_clk();
        op = 2'b00; d_in = 8'hAA; shamt = 4'd1;
        step_clk();
        chk("ign busy pass1", busy, 1);
        chk("ign no early done", done, 0);
        step_clk();
        chk("ign done", done, 1);
        chk("ign d_out", d_out, 8'h3C);
        step_clk();
        chk("ign no requeue busy", busy, 0);
        chk("ign no requeue done", done, 0);
        chk("ign d_out kept", d_out, 8'h3C);
        start = 1'b0;
        step_clk();

        // reset during the second pass aborts with no done pulse
        op = 2'b00; d_in = 8'hFF; shamt = 4'd15; start = 1'b1;
        step_clk();
        start = 1'b0;
        step_clk();
        chk("abort busy before", busy, 1);
        reset = 1'b1;
        step_clk();
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort d_out", d_out, 8'h00);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step_clk();
            chk("abort no done later", done, 0);
        end
        run_cmd(2'b01, 8'hF0, 4'd5, 8'h07, 2, "post_reset_lsr");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
